beat_monitor: RTL and testbench
===============================

Name: beat_monitor

Overview:
- Receive-side companion to the clock-divider beat generators (e.g. the divide-by-32 beat).
- Samples a slow beat signal in the fast `clk` domain and measures its period in `clk` cycles.
- Counts beats, declares frequency lock after a run of in-tolerance periods, and flags loss of lock and dead beats.
- Sits between a beat generator and any consumer that must trust the beat, e.g. a sequencer or display.

Parameters:
- CNT_W, 16: width of the period counter and of `period`.
- EXPECTED, 32: nominal beat period in `clk` cycles.
- TOL, 0: allowed deviation; a period is good iff |period - EXPECTED| <= TOL.
- LOCK_N, 4: consecutive good periods required to assert `locked` (1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- beat_in  input  1  beat to monitor; synchronous to `clk`, no synchronizer inside.
- period  output  CNT_W  last measured period in `clk` cycles.
- period_valid  output  1  one-cycle pulse when `period` updates.
- beat_count  output  8  rising edges seen since reset; wraps 255 -> 0.
- locked  output  1  high while in LOCKED state.
- err  output  1  sticky; set on a bad period or timeout while locked.
- timeout  output  1  one-cycle pulse when the counter saturates.

Behaviour:
- Decided: one clock; reset is synchronous and active-high; ports named `clk` and `rst`.
- Reset values: period=0, period_valid=0, beat_count=0, locked=0, err=0, timeout=0.
- Reset internals: beat_d=1 (no spurious edge if beat_in is high out of reset), cnt=0, good_cnt=0, state=IDLE.
- Reset asserted mid-operation returns everything to reset values on the next edge and discards the partial measurement.
- Edge detect: `edge = beat_in & ~beat_d`; beat_d <= beat_in every cycle. Falling edges are ignored.
- beat_count: increments by 1 on every edge cycle, in any state.
- States:
  - IDLE: cnt held at 0. On edge -> MEASURE. No period output; this edge is the first timestamp.
  - MEASURE: on a non-edge cycle, cnt <= cnt+1. On an edge:
    - period <= cnt+1; period_valid=1 the following cycle; cnt <= 0.
    - Good period: good_cnt <= good_cnt+1. When good_cnt+1 == LOCK_N -> LOCKED and locked=1, registered with period_valid.
    - Bad period: good_cnt <= 0.
  - LOCKED: counts identically to MEASURE.
    - Good period: stay locked.
    - Bad period: err <= 1, locked <= 0, good_cnt <= 0 -> MEASURE.
- Latency:
  - period/period_valid appear 1 cycle after the edge cycle.
  - A constant-period beat asserts locked on the period_valid for edge LOCK_N+1 after reset.
- Saturation:
  - If cnt reaches 2^CNT_W-1 with no edge: timeout pulses 1 cycle, cnt <= 0, good_cnt <= 0, state -> IDLE, locked <= 0.
  - If the timeout happened from LOCKED, err <= 1.
  - period is not updated.
  - An edge on the saturation cycle takes priority: it is treated as a normal edge with period = 2^CNT_W-1, and no timeout.
- err clears only on rst.
- Arithmetic:
  - Tolerance compare is done unsigned, on a CNT_W+1-bit difference; no wrap.
  - good_cnt is 4 bits.

Test Plan:
1. Drive a beat high 16 / low 16 clocks after reset -> period=32 on every period_valid; beat_count increments per edge; locked=1 with the 5th edge's period_valid; err=0.
2. Same generator at period 31, TOL=0 -> period=31 each update; locked stays 0; err stays 0; timeout never.
3. Lock at 32, then one period of 40, then back to 32 -> period=40 with err=1 and locked=0 on that update; locked returns after 4 further 32-periods; err remains 1.
4. CNT_W=6: lock at 32, then hold beat_in low -> timeout pulses exactly once, 63 cycles after the last edge; locked=0; err=1; period still 32; next edge restarts from IDLE with no period output.
5. Assert rst for 1 cycle in the middle of a measurement while locked -> all outputs return to 0 next cycle; beat_in high at reset release gives no edge; first period after reset is measured correctly.
6. Drive 257 edges at period 32 -> beat_count reads 255 after edge 255, 0 after edge 256, 1 after edge 257; locked unaffected by the wrap.

Source files
------------

// File: rtl/beat_monitor.sv
// rtl/beat_monitor.sv - measures the period of a slow beat, counts beats and tracks frequency lock
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   beat_in       beat to monitor, already synchronous to clk
//   period        last measured rising-edge-to-rising-edge period in clk cycles
//   period_valid  one-cycle pulse when period updates
//   beat_count    rising edges seen since reset, wraps 255 -> 0
//   locked        high while the beat has held EXPECTED +/- TOL for LOCK_N periods
//   err           sticky: bad period or timeout while locked; cleared only by rst
//   timeout       one-cycle pulse when the period counter saturates with no edge
module beat_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXPECTED = 32,
  parameter int TOL      = 0,
  parameter int LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       beat_count,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Last count value before saturation: an edge here still yields a
  // legal period of 2^CNT_W-1, a non-edge here is the timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W:0]   EXP_W    = (CNT_W+1)'(EXPECTED);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_W   = 4'(LOCK_N);

  state_t           state_q, state_d;
  logic             beat_d;
  logic             beat_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       good_q, good_d;
  logic [CNT_W-1:0] period_d;
  logic             pv_d, err_d, to_d;
  logic [CNT_W:0]   meas, diff;
  logic             period_good;

  assign beat_edge = beat_in & ~beat_d;
  assign locked    = (state_q == LOCKED);

  // One extra bit so the absolute difference never wraps.
  assign meas        = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign diff        = (meas >= EXP_W) ? (meas - EXP_W) : (EXP_W - meas);
  assign period_good = (diff <= TOL_W);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period;
    pv_d     = 1'b0;
    err_d    = err;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // The first edge is only a timestamp; no period is produced.
        cnt_d = '0;
        if (beat_edge) state_d = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (beat_edge) begin
          period_d = meas[CNT_W-1:0];
          pv_d     = 1'b1;
          cnt_d    = '0;
          if (period_good) begin
            if (state_q == MEASURE) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_W) state_d = LOCKED;
            end
          end else begin
            good_d = '0;
            if (state_q == LOCKED) begin
              err_d   = 1'b1;
              state_d = MEASURE;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          cnt_d   = '0;
          good_d  = '0;
          state_d = IDLE;
          if (state_q == LOCKED) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_d       <= 1'b1;  // beat_in high out of reset must not look like an edge
      cnt_q        <= '0;
      good_q       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      beat_count   <= 8'd0;
      err          <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_d       <= beat_in;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      period       <= period_d;
      period_valid <= pv_d;
      err          <= err_d;
      timeout      <= to_d;
      if (beat_edge) beat_count <= beat_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_beat_monitor.sv
// tb/tb_beat_monitor.sv - directed bench for beat_monitor (16-bit and 6-bit counter instances)
module tb_beat_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        beat_in;
  logic [15:0] period_a;
  logic        pv_a, locked_a, err_a, timeout_a;
  logic [7:0]  bc_a;
  logic [5:0]  period_b;
  logic        pv_b, locked_b, err_b, timeout_b;
  logic [7:0]  bc_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_to_a   = 0;

  logic        cap_pv, cap_lk, cap_err, cap_pv_b;
  logic [15:0] cap_per;
  logic [5:0]  cap_per_b;
  logic [7:0]  cap_bc;

  always #5 clk = ~clk;

  beat_monitor #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .beat_in(beat_in),
    .period(period_a), .period_valid(pv_a), .beat_count(bc_a),
    .locked(locked_a), .err(err_a), .timeout(timeout_a)
  );

  beat_monitor #(.CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .beat_in(beat_in),
    .period(period_b), .period_valid(pv_b), .beat_count(bc_b),
    .locked(locked_b), .err(err_b), .timeout(timeout_b)
  );

  always @(negedge clk) if (timeout_a === 1'b1) n_to_a++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge now, outputs captured one cycle later, total length len cycles.
  task automatic pulse(input int len);
    beat_in = 1'b1;
    tick();
    cap_pv    = pv_a;
    cap_per   = period_a;
    cap_lk    = locked_a;
    cap_err   = err_a;
    cap_bc    = bc_a;
    cap_pv_b  = pv_b;
    cap_per_b = period_b;
    for (int i = 1; i < len; i++) begin
      if (i == len / 2) beat_in = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    beat_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    bit rst_before;
    int len;
    bit exp_pv;
    int exp_period;
    bit exp_locked;
    bit exp_err;
    int exp_bc;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int tcount;
    int tat;

    // period 31, TOL=0: never locks
    tbl[0]  = '{1, 31, 0,  0, 0, 0, 1};
    tbl[1]  = '{0, 31, 1, 31, 0, 0, 2};
    tbl[2]  = '{0, 31, 1, 31, 0, 0, 3};
    tbl[3]  = '{0, 31, 1, 31, 0, 0, 4};
    tbl[4]  = '{0, 31, 1, 31, 0, 0, 5};
    tbl[5]  = '{0, 31, 1, 31, 0, 0, 6};
    // lock at 32, one 40, relock after 4 good periods
    tbl[6]  = '{1, 32, 0,  0, 0, 0, 1};
    tbl[7]  = '{0, 32, 1, 32, 0, 0, 2};
    tbl[8]  = '{0, 32, 1, 32, 0, 0, 3};
    tbl[9]  = '{0, 32, 1, 32, 0, 0, 4};
    tbl[10] = '{0, 32, 1, 32, 1, 0, 5};
    tbl[11] = '{0, 40, 1, 32, 1, 0, 6};
    tbl[12] = '{0, 32, 1, 40, 0, 1, 7};
    tbl[13] = '{0, 32, 1, 32, 0, 1, 8};
    tbl[14] = '{0, 32, 1, 32, 0, 1, 9};
    tbl[15] = '{0, 32, 1, 32, 0, 1, 10};
    tbl[16] = '{0, 32, 1, 32, 1, 1, 11};

    rst     = 1'b1;
    beat_in = 1'b0;
    tick();
    check("rst_period", period_a, 0);
    check("rst_pv", pv_a, 0);
    check("rst_bc", bc_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_err", err_a, 0);
    check("rst_timeout", timeout_a, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 17; v++) begin
      if (tbl[v].rst_before) do_reset();
      pulse(tbl[v].len);
      check($sformatf("v%0d_pv", v), cap_pv, tbl[v].exp_pv);
      check($sformatf("v%0d_period", v), cap_per, tbl[v].exp_period);
      check($sformatf("v%0d_locked", v), cap_lk, tbl[v].exp_locked);
      check($sformatf("v%0d_err", v), cap_err, tbl[v].exp_err);
      check($sformatf("v%0d_bc", v), cap_bc, tbl[v].exp_bc);
    end

    // reset mid-measurement while locked with err set, beat_in high throughout
    beat_in = 1'b1;
    repeat (5) tick();
    check("pre_rst_locked", locked_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_period", period_a, 0);
    check("mid_rst_pv", pv_a, 0);
    check("mid_rst_bc", bc_a, 0);
    check("mid_rst_locked", locked_a, 0);
    check("mid_rst_err", err_a, 0);
    check("mid_rst_timeout", timeout_a, 0);
    repeat (3) tick();
    check("high_release_bc", bc_a, 0);
    beat_in = 1'b0;
    repeat (16) tick();
    pulse(32);
    check("post_rst_first_pv", cap_pv, 0);
    check("post_rst_first_bc", cap_bc, 1);
    pulse(32);
    check("post_rst_pv", cap_pv, 1);
    check("post_rst_period", cap_per, 32);
    check("post_rst_bc", cap_bc, 2);

    // 6-bit counter: lock, then hold low until saturation
    do_reset();
    repeat (5) pulse(32);
    check("sat_prelock", locked_b, 1);
    beat_in = 1'b1;
    tick();
    check("sat_last_pv", pv_b, 1);
    check("sat_last_period", period_b, 32);
    tcount = 0;
    tat    = -1;
    for (int k = 1; k <= 70; k++) begin
      if (k == 16) beat_in = 1'b0;
      tick();
      if (timeout_b === 1'b1) begin
        tcount++;
        if (tat < 0) tat = k;
      end
    end
    check("sat_timeout_count", tcount, 1);
    check("sat_timeout_cycle", tat, 63);
    check("sat_locked", locked_b, 0);
    check("sat_err", err_b, 1);
    check("sat_period_held", period_b, 32);
    pulse(32);
    check("sat_restart_pv", cap_pv_b, 0);
    pulse(32);
    check("sat_next_pv", cap_pv_b, 1);
    check("sat_next_period", cap_per_b, 32);
    check("sat_err_sticky", err_b, 1);

    // beat_count wrap
    do_reset();
    for (int e = 1; e <= 257; e++) begin
      pulse(32);
      if (e == 255) begin
        check("wrap_bc_255", cap_bc, 255);
        check("wrap_locked_255", cap_lk, 1);
      end
      if (e == 256) begin
        check("wrap_bc_256", cap_bc, 0);
        check("wrap_locked_256", cap_lk, 1);
      end
      if (e == 257) begin
        check("wrap_bc_257", cap_bc, 1);
        check("wrap_locked_257", cap_lk, 1);
        check("wrap_err", cap_err, 0);
      end
    end

    check("no_timeout_16bit", n_to_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
